repartidor_carga: RTL and testbench

Sequential inverse of the battery summing path. It takes a 9-bit charge total and distributes it, one unit per clock, round-robin across the packed battery bus. Mode sel=0 uses two 8-bit batteries; sel=1 uses four 4-bit batteries. The resulting 16-bit bus is the same packing the summing block consumes, so the charge loader can feed it directly.

---
 rtl/repartidor_carga_pkg.sv | 29 ++
 rtl/repartidor_carga_if.sv | 21 ++
 rtl/ranura_bateria.sv | 33 +++
 rtl/repartidor_carga.sv | 139 +++++++++++++
 tb/tb_repartidor_carga.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/repartidor_carga_pkg.sv
// Shared types and constants for the charge distributor: FSM states, slot
// geometry per mode and the slot-to-bus bit mapping.
package carga_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } estado_t;

  localparam logic [2:0] N_BAT_8B = 3'd2;
  localparam logic [2:0] N_BAT_4B = 3'd4;
  localparam logic [7:0] MAX_8B   = 8'd255;
  localparam logic [3:0] MAX_4B   = 4'd15;
  localparam logic [8:0] CAP_8B   = 9'd510;
  localparam logic [8:0] CAP_4B   = 9'd60;

  // LSB position of slot idx on the 16-bit bus; slot 0 is the most significant field.
  function automatic logic [3:0] bit_pos(input logic mode, input logic [1:0] idx);
    logic [3:0] pos;
    if (mode) begin
      pos = 4'd12 - {idx, 2'b00};
    end else begin
      pos = idx[0] ? 4'd0 : 4'd8;
    end
    return pos;
  endfunction

endpackage

// File: rtl/repartidor_carga_if.sv
// Request/result bundle of the charge distributor; master drives the request.
interface repartidor_carga_if;
  logic        start;
  logic        sel;
  logic [8:0]  total;
  logic [15:0] baterias;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [8:0]  sobrante;

  modport master (
    output start, sel, total,
    input  baterias, busy, done, overflow, sobrante
  );

  modport slave (
    input  start, sel, total,
    output baterias, busy, done, overflow, sobrante
  );
endinterface

// File: rtl/ranura_bateria.sv
// One battery slot: 8-bit level in mode 0, 4-bit level in mode 1.
// The increment is dropped once the slot is full, so the level never wraps.
module ranura_bateria
  import carga_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  input  logic       mode,
  output logic [7:0] value,
  output logic       full
);

  logic [7:0] value_r;

  // Slot level register; clear has priority over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_r <= 8'd0;
    end else if (clr) begin
      value_r <= 8'd0;
    end else if (inc && !full) begin
      value_r <= value_r + 8'd1;
    end else begin
      value_r <= value_r;
    end
  end

  assign full  = mode ? (value_r == {4'd0, MAX_4B}) : (value_r == MAX_8B);
  assign value = value_r;

endmodule

// File: rtl/repartidor_carga.sv
// Distributes a 9-bit charge total one unit per clock, round-robin, over the
// packed battery bus (2x8-bit or 4x4-bit slots).
module repartidor_carga
  import carga_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  repartidor_carga_if.slave bus
);

  estado_t     state_r;
  logic [8:0]  rem_r;
  logic [1:0]  idx_r;
  logic        mode_r;
  logic        busy_r;
  logic        done_r;
  logic        overflow_r;
  logic [8:0]  sobrante_r;

  logic        clr_s;
  logic [3:0]  inc_s;
  logic [3:0]  full_s;
  logic [7:0]  valor_s [4];
  logic        all_full_s;
  logic [2:0]  n_s;
  logic [1:0]  idx_next_s;
  logic [15:0] bat_s;

  // Slots 2 and 3 only exist in 4-bit mode; in 8-bit mode they are held at zero.
  for (genvar i = 0; i < 4; i++) begin : g_ranura
    ranura_bateria u_ranura (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc_s[i]),
      .clr   (clr_s | ((i >= 2) && !mode_r)),
      .mode  (mode_r),
      .value (valor_s[i]),
      .full  (full_s[i])
    );
  end

  assign all_full_s = mode_r ? (&full_s) : (&full_s[1:0]);
  assign n_s        = mode_r ? N_BAT_4B : N_BAT_8B;

  // Slot control: clear on accepted start, deposit into the current slot when it has room.
  always_comb begin
    clr_s      = (state_r == IDLE) && bus.start;
    inc_s      = 4'd0;
    idx_next_s = idx_r + 2'd1;
    if (({1'b0, idx_r} + 3'd1) == n_s) begin
      idx_next_s = 2'd0;
    end else begin
      idx_next_s = idx_r + 2'd1;
    end
    if ((state_r == FILL) && (rem_r != 9'd0) && !all_full_s) begin
      inc_s[idx_r] = !full_s[idx_r];
    end else begin
      inc_s = 4'd0;
    end
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      rem_r      <= 9'd0;
      idx_r      <= 2'd0;
      mode_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      overflow_r <= 1'b0;
      sobrante_r <= 9'd0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            mode_r     <= bus.sel;
            rem_r      <= bus.total;
            idx_r      <= 2'd0;
            overflow_r <= 1'b0;
            sobrante_r <= 9'd0;
            busy_r     <= 1'b1;
            state_r    <= FILL;
          end
        end
        FILL: begin
          if (rem_r == 9'd0) begin
            overflow_r <= 1'b0;
            sobrante_r <= 9'd0;
            done_r     <= 1'b1;
            state_r    <= DONE;
          end else if (all_full_s) begin
            overflow_r <= 1'b1;
            sobrante_r <= rem_r;
            done_r     <= 1'b1;
            state_r    <= DONE;
          end else begin
            if (inc_s != 4'd0) begin
              rem_r <= rem_r - 9'd1;
            end
            idx_r <= idx_next_s;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Pack slot levels onto the bus in the layout of the current mode.
  always_comb begin
    bat_s = 16'd0;
    if (mode_r) begin
      for (int i = 0; i < 4; i++) begin
        bat_s[bit_pos(1'b1, 2'(i)) +: 4] = valor_s[i][3:0];
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bat_s[bit_pos(1'b0, 2'(i)) +: 8] = valor_s[i];
      end
    end
  end

  assign bus.baterias = bat_s;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.overflow = overflow_r;
  assign bus.sobrante = sobrante_r;

endmodule

// File: tb/tb_repartidor_carga.sv
// Directed, table-driven bench for repartidor_carga plus hand-written
// sequences for start-during-DONE and asynchronous reset mid-FILL.
module tb_repartidor_carga;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  repartidor_carga_if bus_if ();

  repartidor_carga dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [8:0]  total;
    logic [15:0] bat;
    logic        ovf;
    logic [8:0]  sob;
    int          lat;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int   lat;
    int   busy_cnt;
    logic seen;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.sel   = v.sel;
    bus_if.total = v.total;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    bus_if.sel   = ~v.sel;
    bus_if.total = 9'h1AA;
    lat      = 0;
    busy_cnt = bus_if.busy ? 1 : 0;
    seen     = 1'b0;
    while (!seen && lat < 600) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus_if.busy) busy_cnt++;
      if (bus_if.done) seen = 1'b1;
    end
    $display("vector %0d: sel=%0d total=%0d latency=%0d", n, v.sel, v.total, lat);
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("latency", lat, v.lat);
    chk("baterias", {16'd0, bus_if.baterias}, {16'd0, v.bat});
    chk("overflow", {31'd0, bus_if.overflow}, {31'd0, v.ovf});
    chk("sobrante", {23'd0, bus_if.sobrante}, {23'd0, v.sob});
    chk("busy_cycles", busy_cnt, v.lat + 1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulse", {31'd0, bus_if.done}, 32'd0);
    chk("busy_idle", {31'd0, bus_if.busy}, 32'd0);
    chk("bat_held", {16'd0, bus_if.baterias}, {16'd0, v.bat});
    chk("ovf_held", {31'd0, bus_if.overflow}, {31'd0, v.ovf});
    chk("sob_held", {23'd0, bus_if.sobrante}, {23'd0, v.sob});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus_if.start = 1'b0;
    bus_if.sel   = 1'b0;
    bus_if.total = 9'd0;

    vecs[0]  = '{1'b0, 9'd5,   16'h0302, 1'b0, 9'd0,  6};
    vecs[1]  = '{1'b1, 9'd10,  16'h3322, 1'b0, 9'd0,  11};
    vecs[2]  = '{1'b0, 9'd511, 16'hFFFF, 1'b1, 9'd1,  511};
    vecs[3]  = '{1'b1, 9'd100, 16'hFFFF, 1'b1, 9'd40, 61};
    vecs[4]  = '{1'b0, 9'd0,   16'h0000, 1'b0, 9'd0,  1};
    vecs[5]  = '{1'b1, 9'd0,   16'h0000, 1'b0, 9'd0,  1};
    vecs[6]  = '{1'b1, 9'd7,   16'h2221, 1'b0, 9'd0,  8};
    vecs[7]  = '{1'b0, 9'd510, 16'hFFFF, 1'b0, 9'd0,  511};
    vecs[8]  = '{1'b1, 9'd60,  16'hFFFF, 1'b0, 9'd0,  61};
    vecs[9]  = '{1'b1, 9'd61,  16'hFFFF, 1'b1, 9'd1,  61};
    vecs[10] = '{1'b0, 9'd3,   16'h0201, 1'b0, 9'd0,  4};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_baterias", {16'd0, bus_if.baterias}, 32'd0);
    chk("rst_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("rst_done", {31'd0, bus_if.done}, 32'd0);
    chk("rst_overflow", {31'd0, bus_if.overflow}, 32'd0);
    chk("rst_sobrante", {23'd0, bus_if.sobrante}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 11; k++) begin
      run_vec(k, vecs[k]);
    end

    // total=0 with start held high through FILL and DONE: no re-acceptance.
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.sel   = 1'b0;
    bus_if.total = 9'd0;
    @(posedge clk);
    #1;
    bus_if.sel   = 1'b1;
    bus_if.total = 9'd7;
    @(posedge clk);
    #1;
    chk("zero_done", {31'd0, bus_if.done}, 32'd1);
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    chk("zero_ignore_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("zero_ignore_done", {31'd0, bus_if.done}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("zero_still_idle", {31'd0, bus_if.busy}, 32'd0);
    chk("zero_bat", {16'd0, bus_if.baterias}, 32'd0);

    // Asynchronous reset 50 cycles into a 200-unit fill, then a fresh request.
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.sel   = 1'b0;
    bus_if.total = 9'd200;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("mid_fill_bat", {16'd0, bus_if.baterias}, 32'h1919);
    chk("mid_fill_busy", {31'd0, bus_if.busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_baterias", {16'd0, bus_if.baterias}, 32'd0);
    chk("arst_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("arst_done", {31'd0, bus_if.done}, 32'd0);
    chk("arst_overflow", {31'd0, bus_if.overflow}, 32'd0);
    chk("arst_sobrante", {23'd0, bus_if.sobrante}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(11, vecs[6]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
